// File: rtl/state_mon_pkg.sv
// ---------------------------------------------------------------------------
// state_mon_pkg
//   Definitions shared by the input debouncer and the state monitor:
//   - FSM state encoding of the debouncer (2-bit, legacy-compatible values)
//   - default settle window and monitored bus width
//   - saturating increment used by the 8-bit event counter
// ---------------------------------------------------------------------------
package state_mon_pkg;

  // Debouncer FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // 100 cycles = 10 ms at a 10 kHz system clock
  localparam int unsigned DEFAULT_SETTLE_CYCLES = 100;

  // Width of the dedicated input bus seen by the monitor
  localparam int MON_WIDTH = 8;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   Bit-parallel multi-flop synchroniser for an asynchronous bus. Each bit
//   passes through STAGES back-to-back flops with no logic in between.
// Ports
//   clk     in   1      destination clock
//   reset   in   1      asynchronous, active-high; clears every stage to 0
//   din_i   in   WIDTH  asynchronous input bus
//   sync_o  out  WIDTH  output of the last stage
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // NOTE: the stage array is a handful of flops, not a RAM, so it is reset
  // like any other register; a known value after reset keeps the downstream
  // FSM from seeing a spurious change on the first cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, giving a true shift; blocking would collapse the
      // chain into a single flop.
      stage_q[0] <= din_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/state_input_debouncer.sv
// ---------------------------------------------------------------------------
// state_input_debouncer
//   Upstream conditioning stage for the state monitor. Synchronises the raw
//   input bus, rejects changes that do not hold for SETTLE_CYCLES cycles and
//   publishes a stable bus with a one-cycle change strobe. All outputs are
//   registered.
// Ports
//   clk          in   1      system clock
//   reset        in   1      asynchronous, active-high
//   ena          in   1      1 = debouncing active; 0 = hold IDLE, no commits
//   din          in   WIDTH  raw asynchronous input bus
//   clear_count  in   1      one-cycle pulse, zeroes event_count
//   dout         out  WIDTH  debounced stable bus
//   change_stb   out  1      one cycle high when dout updates
//   change_mask  out  WIDTH  bits flipped on the last commit (held)
//   glitch_stb   out  1      one cycle high when din fell back to dout early
//   busy         out  1      high while the FSM is not IDLE
//   event_count  out  8      committed changes since reset/clear, saturating
// ---------------------------------------------------------------------------
module state_input_debouncer
  import state_mon_pkg::*;
#(
  parameter int          WIDTH         = MON_WIDTH,
  parameter int          SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  input  logic             clear_count,
  output logic [WIDTH-1:0] dout,
  output logic             change_stb,
  output logic [WIDTH-1:0] change_mask,
  output logic             glitch_stb,
  output logic             busy,
  output logic [7:0]       event_count
);

  // Terminal count of the settle window; the counter never passes it
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [WIDTH-1:0] sync;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             change_stb_q, change_stb_d;
  logic             glitch_stb_q, glitch_stb_d;
  logic             busy_q, busy_d;
  logic [7:0]       event_count_q, event_count_d;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .din_i  (din),
    .sync_o (sync)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    dout_d        = dout_q;
    mask_d        = mask_q;
    change_stb_d  = 1'b0;
    glitch_stb_d  = 1'b0;
    event_count_d = event_count_q;

    case (state_q)
      ST_IDLE: begin
        if (ena && (sync != dout_q)) begin
          state_d = ST_SETTLE;
          cand_d  = sync;
          cnt_d   = '0;
        end
      end

      ST_SETTLE: begin
        if (!ena) begin
          // Abort silently; the change is re-evaluated from scratch later
          state_d = ST_IDLE;
        end else if (sync == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_COMMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sync == dout_q) begin
          // Input bounced back to the committed value before settling
          state_d      = ST_IDLE;
          glitch_stb_d = 1'b1;
        end else begin
          // New value: restart the full window, no partial credit
          cand_d = sync;
          cnt_d  = '0;
        end
      end

      ST_COMMIT: begin
        // Unconditional, even if ena dropped during the last settle cycle
        dout_d        = cand_q;
        mask_d        = cand_q ^ dout_q;
        change_stb_d  = 1'b1;
        event_count_d = sat_inc8(event_count_q);
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear has priority over a simultaneous commit
    if (clear_count) begin
      event_count_d = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      dout_q        <= '0;
      mask_q        <= '0;
      change_stb_q  <= 1'b0;
      glitch_stb_q  <= 1'b0;
      busy_q        <= 1'b0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      dout_q        <= dout_d;
      mask_q        <= mask_d;
      change_stb_q  <= change_stb_d;
      glitch_stb_q  <= glitch_stb_d;
      busy_q        <= busy_d;
      event_count_q <= event_count_d;
    end
  end

  assign dout        = dout_q;
  assign change_mask = mask_q;
  assign change_stb  = change_stb_q;
  assign glitch_stb  = glitch_stb_q;
  assign busy        = busy_q;
  assign event_count = event_count_q;

endmodule

// File: tb/tb_state_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_state_input_debouncer
//   Directed stimulus for state_input_debouncer with SYNC_STAGES=2 and
//   SETTLE_CYCLES=4. Each stimulus step pushes the strobe it expects (kind,
//   arrival cycle, dout, change_mask, event_count) into a queue; a monitor
//   on the falling edge pops and compares whenever a strobe is seen.
//   A din change driven on the falling edge after rising edge c commits at
//   rising edge c+8 (S+N+2).
// ---------------------------------------------------------------------------
module tb_state_input_debouncer;

  localparam int WIDTH = 8;
  localparam int S     = 2;
  localparam int N     = 4;
  localparam int LAT   = S + N + 2;

  logic             clk;
  logic             reset;
  logic             ena;
  logic [WIDTH-1:0] din;
  logic             clear_count;
  logic [WIDTH-1:0] dout;
  logic             change_stb;
  logic [WIDTH-1:0] change_mask;
  logic             glitch_stb;
  logic             busy;
  logic [7:0]       event_count;

  state_input_debouncer #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (S),
    .SETTLE_CYCLES (N),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .din         (din),
    .clear_count (clear_count),
    .dout        (dout),
    .change_stb  (change_stb),
    .change_mask (change_mask),
    .glitch_stb  (glitch_stb),
    .busy        (busy),
    .event_count (event_count)
  );

  typedef struct {
    bit         glitch;
    logic [7:0] dout;
    logic [7:0] mask;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model of the committed state
  logic [7:0] exp_dout  = 8'h00;
  logic [7:0] exp_mask  = 8'h00;
  logic [7:0] exp_count = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] next_count(input logic [7:0] n);
    if (n >= 8'd255) return 8'd255;
    return n + 8'd1;
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new din value and expect it to commit after the full latency
  task automatic commit_to(input logic [7:0] v);
    exp_t e;
    e.glitch  = 1'b0;
    e.dout    = v;
    e.mask    = v ^ exp_dout;
    e.cnt     = next_count(exp_count);
    e.cyc     = cyc + LAT;
    din       = v;
    sb.push_back(e);
    exp_mask  = e.mask;
    exp_dout  = v;
    exp_count = e.cnt;
    wait_neg(LAT + 2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"},        32'(dout),        32'h0);
    check({tag, "_mask"},        32'(change_mask), 32'h0);
    check({tag, "_count"},       32'(event_count), 32'h0);
    check({tag, "_busy"},        32'(busy),        32'h0);
    check({tag, "_change_stb"},  32'(change_stb),  32'h0);
    check({tag, "_glitch_stb"},  32'(glitch_stb),  32'h0);
  endtask

  // Monitor: compares every strobe against the head of the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        check("missed_strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
      if (change_stb || glitch_stb) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'd0, change_stb, glitch_stb}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("strobe_kind",  {30'd0, change_stb, glitch_stb},
                mon_e.glitch ? 32'd1 : 32'd2);
          check("strobe_cycle", 32'(cyc),         32'(mon_e.cyc));
          check("dout",         32'(dout),        32'(mon_e.dout));
          check("change_mask",  32'(change_mask), 32'(mon_e.mask));
          check("event_count",  32'(event_count), 32'(mon_e.cnt));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   c;

    reset       = 1'b0;
    ena         = 1'b1;
    din         = 8'h00;
    clear_count = 1'b0;
    #1 reset = 1'b1;
    #1 check_all_zero("reset");
    wait_neg(2);
    reset = 1'b0;
    wait_neg(2);

    // T1: 00 -> 5A commits after S+N+2 edges
    commit_to(8'h5A);
    check("t1_busy_idle", 32'(busy), 32'h0);
    check("t1_count",     32'(event_count), 32'd1);

    // Return to 00 so the glitch test starts from a clean bus
    commit_to(8'h00);

    // T2: 01 for two cycles then back to 00 -> glitch, no commit
    c   = cyc;
    din = 8'h01;
    e.glitch = 1'b1; e.dout = exp_dout; e.mask = exp_mask;
    e.cnt    = exp_count; e.cyc = c + 5;
    sb.push_back(e);
    wait_neg(2);
    din = 8'h00;
    wait_neg(1);
    check("t2_busy_settle", 32'(busy), 32'h1);
    wait_neg(6);
    check("t2_busy_idle", 32'(busy), 32'h0);
    check("t2_dout",      32'(dout), 32'h00);
    check("t2_count",     32'(event_count), 32'd2);

    // T3: bounce 00 -> 03 -> 01; window restarts at the last change
    c   = cyc;
    din = 8'h03;
    wait_neg(1);
    din = 8'h01;
    e.glitch = 1'b0; e.dout = 8'h01; e.mask = 8'h01;
    e.cnt    = 8'd3; e.cyc = c + 1 + LAT;
    sb.push_back(e);
    exp_dout = 8'h01; exp_mask = 8'h01; exp_count = 8'd3;
    wait_neg(12);

    // T4: ena drops mid-window, then a fresh full window on re-enable
    din = 8'h10;
    wait_neg(4);
    ena = 1'b0;
    wait_neg(2);
    check("t4_busy_disabled", 32'(busy), 32'h0);
    wait_neg(1);
    c   = cyc;
    ena = 1'b1;
    e.glitch = 1'b0; e.dout = 8'h10; e.mask = 8'h11;
    e.cnt    = 8'd4; e.cyc = c + N + 2;
    sb.push_back(e);
    exp_dout = 8'h10; exp_mask = 8'h11; exp_count = 8'd4;
    wait_neg(10);

    // T5: drive the counter past 255 and verify saturation
    for (int i = 0; i < 253; i++) begin
      commit_to(~exp_dout);
    end
    check("t5_saturated", 32'(event_count), 32'd255);

    // Clear on the same edge as a commit: clear wins, strobe still fires
    c   = cyc;
    din = 8'hC3;
    e.glitch = 1'b0; e.dout = 8'hC3; e.mask = 8'hC3 ^ exp_dout;
    e.cnt    = 8'd0; e.cyc = c + LAT;
    sb.push_back(e);
    exp_mask = e.mask; exp_dout = 8'hC3; exp_count = 8'd0;
    wait_neg(LAT - 1);
    clear_count = 1'b1;
    wait_neg(1);
    clear_count = 1'b0;
    wait_neg(2);
    check("t5_cleared", 32'(event_count), 32'd0);
    commit_to(8'h3C);

    // T6: async reset mid-window, then AA commits after release
    din = 8'hAA;
    wait_neg(4);
    #2 reset = 1'b1;
    #1 check_all_zero("t6_reset");
    exp_dout = 8'h00; exp_mask = 8'h00; exp_count = 8'd0;
    wait_neg(2);
    reset = 1'b0;
    c     = cyc;
    e.glitch = 1'b0; e.dout = 8'hAA; e.mask = 8'hAA;
    e.cnt    = 8'd1; e.cyc = c + LAT;
    sb.push_back(e);
    wait_neg(12);
    check("t6_dout", 32'(dout), 32'hAA);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
